fu_wb_queue: RTL and testbench

Writeback queue sitting directly downstream of a long-latency functional unit such as the divider. The FU produces a single-cycle result pulse with no backpressure; this block catches that pulse in a small FIFO and presents it to the shared writeback/bypass port under valid/ready. It reserves a slot when an op is issued to the FU, so a result never arrives to a full queue. A squash flushes the queue and all reservations.

---
 rtl/fu_wb_queue_pkg.sv | 26 ++
 rtl/squash_if.sv | 6 +
 rtl/fu_wb_queue.sv | 102 ++++++++++
 tb/tb_fu_wb_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_wb_queue_pkg.sv
// Shared FU result types and queue helpers.
package fu_wb_queue_pkg;

  localparam int unsigned PcW  = 32;
  localparam int unsigned IdW  = 8;
  localparam int unsigned PrdW = 6;
  localparam int unsigned XLen = 32;

  typedef logic [PcW-1:0]  pc_t;
  typedef logic [IdW-1:0]  id_t;
  typedef logic [PrdW-1:0] prd_t;
  typedef logic [XLen-1:0] xlen_t;

  typedef struct packed {
    pc_t   pc;
    id_t   id;
    prd_t  prd;
    xlen_t rdval;
  } fu_output_t;

  // Circular pointer advance; explicit compare keeps non-power-of-two depths correct.
  function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/squash_if.sv
// Pipeline squash broadcast; only valid is carried.
interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_queue.sv
// Writeback queue behind a long-latency FU. Slots are reserved at issue so an
// FU result pulse (no backpressure) always has room; results drain under
// valid/ready. Squash clears all entries and reservations.
module fu_wb_queue
  import fu_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       issue_i,
  output logic                       credit_o,
  input  fu_output_t                 fuoutput_i,
  input  logic                       fuoutput_i_valid,
  output fu_output_t                 wb_o,
  output logic                       wb_o_valid,
  input  logic                       wb_i_ready,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  squash_if.slave                    squash_io
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fu_output_t    storage_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] resv_q, resv_d;
  logic [CntW:0]   occupied;
  logic            squash;
  logic            reserve;
  logic            push;
  logic            pop;

  // Event decode; outputs depend on registers only.
  always_comb begin
    squash     = squash_io.valid;
    occupied   = {1'b0, count_q} + {1'b0, resv_q};
    credit_o   = occupied < (CntW + 1)'(DEPTH);
    wb_o_valid = count_q != '0;
    count_o    = count_q;
    wb_o       = storage_q[rd_ptr_q];
    reserve    = issue_i && credit_o;
    // A result without a reservation has nowhere guaranteed to go: drop it.
    push       = fuoutput_i_valid && (resv_q != '0);
    pop        = wb_o_valid && wb_i_ready;
  end

  // Next-state: net deltas so simultaneous events compose.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    resv_d   = resv_q + CntW'(reserve) - CntW'(push);
    if (pop)  rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), DEPTH));
    if (push) wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), DEPTH));
    if (squash) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      resv_d   = '0;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      resv_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      resv_q   <= resv_d;
    end
  end

  // Result storage, not reset; a squashed push is never written.
  always_ff @(posedge clk) begin
    if (push && !squash) begin
      storage_q[wr_ptr_q] <= fuoutput_i;
    end
  end

`ifdef INC_ASSERT
  a_issue_needs_credit : assert property (@(posedge clk) disable iff (!rstn)
    issue_i |-> credit_o)
    else $error("issue without credit");

  a_result_needs_resv : assert property (@(posedge clk) disable iff (!rstn)
    fuoutput_i_valid |-> (resv_q != '0))
    else $error("FU result without reservation");

  a_occupancy_bound : assert property (@(posedge clk) disable iff (!rstn)
    occupied <= (CntW + 1)'(DEPTH))
    else $error("count + reservations exceed depth");
`endif

endmodule

// File: tb/tb_fu_wb_queue.sv
// Randomized + directed bench for fu_wb_queue against a queue-level model.
module tb_fu_wb_queue;
  import fu_wb_queue_pkg::*;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic            issue;
  logic            credit;
  fu_output_t      fu_in;
  logic            fu_valid;
  fu_output_t      wb;
  logic            wb_valid;
  logic            ready;
  logic [CntW-1:0] count;
  logic            squash;

  squash_if sq ();
  assign sq.valid = squash;

  fu_wb_queue #(.DEPTH(DEPTH)) u_dut (
    .clk              (clk),
    .rstn             (rstn),
    .issue_i          (issue),
    .credit_o         (credit),
    .fuoutput_i       (fu_in),
    .fuoutput_i_valid (fu_valid),
    .wb_o             (wb),
    .wb_o_valid       (wb_valid),
    .wb_i_ready       (ready),
    .count_o          (count),
    .squash_io        (sq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: ordered list of held results plus an outstanding-reservation count.
  fu_output_t mq[$];
  int         m_resv = 0;
  int         popped_ids[$];

  function automatic bit m_credit();
    return (mq.size() + m_resv) < DEPTH;
  endfunction

  always @(posedge clk or negedge rstn) begin
    bit do_pop, do_push, do_res;
    if (!rstn) begin
      mq.delete();
      m_resv = 0;
    end else if (squash) begin
      mq.delete();
      m_resv = 0;
    end else begin
      do_pop  = (mq.size() > 0) && ready;
      do_push = fu_valid && (m_resv > 0);
      do_res  = issue && m_credit();
      if (do_pop) begin
        popped_ids.push_back(int'(mq[0].id));
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(fu_in);
      m_resv = m_resv + int'(do_res) - int'(do_push);
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      check("valid", wb_valid, mq.size() > 0);
      check("count", count, mq.size());
      check("credit", credit, m_credit());
      if (mq.size() > 0) check("head", wb, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_result(input int id, input logic [31:0] val);
    fu_in.pc    = 32'h1000 + 32'(id) * 4;
    fu_in.id    = id_t'(id);
    fu_in.prd   = prd_t'(id);
    fu_in.rdval = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, pushed, base, cyc;
    rstn = 1'b0; issue = 1'b0; fu_valid = 1'b0; ready = 1'b0; squash = 1'b0;
    set_result(0, 32'h0);
    #1;
    check("rst_valid", wb_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_credit", credit, 1'b1);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Single result: reserve, idle, push id 5 with ready high.
    issue = 1'b1; tick();
    issue = 1'b0; tick();
    check("t1_pre_valid", wb_valid, 1'b0);
    set_result(5, 32'h2A); fu_valid = 1'b1; ready = 1'b1; tick();
    fu_valid = 1'b0;
    check("t1_valid", wb_valid, 1'b1);
    check("t1_id", wb.id, 5);
    check("t1_rdval", wb.rdval, 32'h2A);
    tick();
    check("t1_drained_valid", wb_valid, 1'b0);
    check("t1_drained_count", count, 0);

    // Fill to DEPTH with ready low, then drain.
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      issue = 1'b1; tick();
    end
    issue = 1'b0;
    check("t2_credit_full", credit, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      set_result(i, 32'(i * 3)); fu_valid = 1'b1; tick();
    end
    fu_valid = 1'b0;
    check("t2_count_full", count, DEPTH);
    check("t2_credit_still0", credit, 1'b0);
    ready = 1'b1;
    check("t2_head1", wb.id, 1);
    tick();
    check("t2_credit_reopen", credit, 1'b1);
    check("t2_head2", wb.id, 2);
    tick();
    check("t2_head3", wb.id, 3);
    tick();
    check("t2_empty", count, 0);
    ready = 1'b0;

    // Push and pop together at count 1: count holds, new head is the pushed entry.
    issue = 1'b1; tick(); tick();
    issue = 1'b0;
    set_result(20, 32'hAA); fu_valid = 1'b1; tick();
    set_result(21, 32'hBB); ready = 1'b1; tick();
    fu_valid = 1'b0;
    check("t4_count", count, 1);
    check("t4_head", wb.id, 21);
    tick();
    ready = 1'b0;
    tick();

    // Squash with two entries, one reservation and a concurrent push.
    issue = 1'b1; tick(); tick(); tick();
    issue = 1'b0;
    set_result(30, 32'h30); fu_valid = 1'b1; tick();
    set_result(31, 32'h31); tick();
    set_result(32, 32'h32); squash = 1'b1; tick();
    squash = 1'b0; fu_valid = 1'b0;
    check("t5_valid", wb_valid, 1'b0);
    check("t5_count", count, 0);
    check("t5_credit", credit, 1'b1);
    ready = 1'b1; tick(); tick();
    check("t5_no_ghost", wb_valid, 1'b0);
    ready = 1'b0;

    // Result without reservation is dropped.
    issue = 1'b1; tick();
    issue = 1'b0;
    set_result(40, 32'h40); fu_valid = 1'b1; tick();
    set_result(41, 32'h41); tick();
    fu_valid = 1'b0;
    check("t6_count", count, 1);
    check("t6_head", wb.id, 40);
    ready = 1'b1; tick(); ready = 1'b0;

    // Eight results streamed with ready toggling, across pointer wrap.
    popped_ids.delete();
    issued = 0; pushed = 0; base = 50; cyc = 0;
    while (popped_ids.size() < 8 && cyc < 200) begin
      issue = (issued < 8) && m_credit();
      fu_valid = (pushed < 8) && (m_resv > 0);
      set_result(base + pushed, $urandom);
      ready = cyc[0];
      if (issue) issued++;
      if (fu_valid) pushed++;
      tick();
      cyc++;
    end
    issue = 1'b0; fu_valid = 1'b0; ready = 1'b0;
    check("t3_popped", popped_ids.size(), 8);
    for (int i = 0; i < 8 && i < popped_ids.size(); i++) begin
      check("t3_order", popped_ids[i], base + i);
    end

    // Randomized traffic including occasional squash.
    for (int i = 0; i < 400; i++) begin
      issue    = ($urandom_range(1, 0) == 1) && m_credit();
      fu_valid = (m_resv > 0) && ($urandom_range(2, 0) != 0);
      set_result(int'($urandom_range(255, 0)), $urandom);
      ready    = $urandom_range(3, 0) != 0;
      squash   = $urandom_range(49, 0) == 0;
      tick();
    end
    squash = 1'b0;

    // Mid-operation reset clears immediately.
    ready = 1'b0; fu_valid = 1'b0;
    issue = m_credit(); tick();
    issue = 1'b0;
    if (m_resv > 0) begin
      fu_valid = 1'b1; tick(); fu_valid = 1'b0;
    end
    rstn = 1'b0;
    #1;
    check("mrst_valid", wb_valid, 1'b0);
    check("mrst_count", count, 0);
    check("mrst_credit", credit, 1'b1);
    tick();
    rstn = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
